// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network datapath blocks.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   function automatic int accw(input int nc, input int wv);
      return $clog2(nc) + wv;
   endfunction

   // Clamp a sign-extended value into the signed range of a wv-bit word.
   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int wv);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (wv - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (wv - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/maccum_lane.sv
// One neuron lane: signed multiply, fixed-point realign, WA-bit accumulate.
// Realigned product wraps to WV bits unless FORWARD_MACCUM_SAT_EN is defined.
module maccum_lane
   import nn_pkg::*;
#(
   parameter int WV = 5,
   parameter int WF = 2,
   parameter int WA = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic signed [WV-1:0] w_i,
   input  logic signed [WV-1:0] s_i,
   output logic signed [WA-1:0] acc_o
);

   localparam int PW = 2 * WV;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic signed [WV-1:0] term;
   logic signed [WA-1:0] acc_d;
   logic signed [WA-1:0] acc_q;

   always_comb begin
      prod    = w_i * s_i;
      shifted = prod >>> WF;
`ifdef FORWARD_MACCUM_SAT_EN
      term    = WV'(sat_clip(64'(shifted), WV));
`else
      term    = WV'(shifted);
`endif
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + WA'(term);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/forward_maccum.sv
// Forward-path MAC: NN lanes walk the NC columns one per cycle; result held in DONE until taken.
// Build option FORWARD_MACCUM_SAT_EN saturates each realigned product instead of wrapping.
module forward_maccum
   import nn_pkg::*;
#(
   parameter int    NN    = 7,
   parameter int    NC    = 11,
   parameter int    WV    = 5,
   parameter int    WF    = 2,
   parameter string BURST = "yes",
   localparam int   WA    = accw(NC, WV)
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iValid_AM_Weight,
   output logic                  oReady_AM_Weight,
   input  logic [NC*NN*WV-1:0]   iData_AM_Weight,
   input  logic                  iValid_AM_Signal,
   output logic                  oReady_AM_Signal,
   input  logic [NC*WV-1:0]      iData_AM_Signal,
   output logic                  oValid_BM_Accum,
   input  logic                  iReady_BM_Accum,
   output logic [NN*WA-1:0]      oData_BM_Accum
);

   localparam int CW       = $clog2(NC);
   localparam bit BURST_EN = (BURST == "yes");

   fsm_e                  state_q;
   logic [CW-1:0]         col_q;
   logic                  vld_q;
   logic [NC*NN*WV-1:0]   w_q;
   logic [NC*WV-1:0]      s_q;

   logic                  acc_en;
   logic                  accept;
   logic                  lane_en;
   logic signed [WV-1:0]  s_sel;

   // Both operands are taken together; a lone valid never advances anything.
   assign acc_en  = (state_q == IDLE) ||
                    ((state_q == DONE) && iReady_BM_Accum && BURST_EN);
   assign accept  = acc_en && iValid_AM_Weight && iValid_AM_Signal;
   assign lane_en = (state_q == ACCUM);

   assign oReady_AM_Weight = acc_en && iValid_AM_Signal;
   assign oReady_AM_Signal = acc_en && iValid_AM_Weight;
   assign oValid_BM_Accum  = vld_q;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= IDLE;
         col_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ACCUM;
                  col_q   <= '0;
               end
            end
            ACCUM: begin
               if (col_q == CW'(NC - 1)) begin
                  state_q <= DONE;
                  vld_q   <= 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            DONE: begin
               if (iReady_BM_Accum) begin
                  vld_q   <= 1'b0;
                  col_q   <= '0;
                  state_q <= accept ? ACCUM : IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               col_q   <= '0;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         w_q <= '0;
         s_q <= '0;
      end else if (accept) begin
         w_q <= iData_AM_Weight;
         s_q <= iData_AM_Signal;
      end
   end

   assign s_sel = s_q[int'(col_q)*WV +: WV];

   for (genvar n = 0; n < NN; n++) begin : g_lane
      logic signed [WV-1:0] w_sel;

      assign w_sel = w_q[(int'(col_q)*NN + n)*WV +: WV];

      maccum_lane #(
         .WV (WV),
         .WF (WF),
         .WA (WA)
      ) u_lane (
         .clk_i  (iCLK),
         .rst_ni (iRST),
         .clr_i  (accept),
         .en_i   (lane_en),
         .w_i    (w_sel),
         .s_i    (s_sel),
         .acc_o  (oData_BM_Accum[n*WA +: WA])
      );
   end

endmodule

// File: tb/tb_forward_maccum.sv
// Directed vectors plus hand-built corner sequences for forward_maccum (NN=2, NC=3, WV=8, WF=4).
module tb_forward_maccum;

   localparam int NN = 2;
   localparam int NC = 3;
   localparam int WV = 8;
   localparam int WF = 4;
   localparam int WA = 10;

`ifdef FORWARD_MACCUM_SAT_EN
   localparam int OV0 = 127;
   localparam int OV1 = -128;
`else
   localparam int OV0 = -16;
   localparam int OV1 = 8;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC*NN*WV-1:0] w_dat;
   logic [NC*WV-1:0]    s_dat;
   logic                w_vld, s_vld, w_rdy, s_rdy, o_vld, o_rdy;
   logic [NN*WA-1:0]    o_dat;
   logic                n_w_vld, n_s_vld, n_w_rdy, n_s_rdy, n_o_vld, n_o_rdy;
   logic [NN*WA-1:0]    n_o_dat;

   forward_maccum #(.NN(NN), .NC(NC), .WV(WV), .WF(WF), .BURST("yes")) dut_b (
      .iCLK(clk), .iRST(rst_n),
      .iValid_AM_Weight(w_vld), .oReady_AM_Weight(w_rdy), .iData_AM_Weight(w_dat),
      .iValid_AM_Signal(s_vld), .oReady_AM_Signal(s_rdy), .iData_AM_Signal(s_dat),
      .oValid_BM_Accum(o_vld), .iReady_BM_Accum(o_rdy), .oData_BM_Accum(o_dat)
   );

   forward_maccum #(.NN(NN), .NC(NC), .WV(WV), .WF(WF), .BURST("no")) dut_n (
      .iCLK(clk), .iRST(rst_n),
      .iValid_AM_Weight(n_w_vld), .oReady_AM_Weight(n_w_rdy), .iData_AM_Weight(w_dat),
      .iValid_AM_Signal(n_s_vld), .oReady_AM_Signal(n_s_rdy), .iData_AM_Signal(s_dat),
      .oValid_BM_Accum(n_o_vld), .iReady_BM_Accum(n_o_rdy), .oData_BM_Accum(n_o_dat)
   );

   typedef struct {
      logic [NN-1:0][NC-1:0][WV-1:0] wt;
      logic [NC-1:0][WV-1:0]         sg;
      int                            e0;
      int                            e1;
   } vec_t;

   vec_t tbl[5];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic int lane(input logic [NN*WA-1:0] d, input int n);
      logic signed [WA-1:0] t;
      t = d[n*WA +: WA];
      return int'(t);
   endfunction

   function automatic vec_t mk(input int a0, a1, a2, b0, b1, b2, s0, s1, s2, e0, e1);
      vec_t v;
      v.wt[0][0] = WV'(a0); v.wt[0][1] = WV'(a1); v.wt[0][2] = WV'(a2);
      v.wt[1][0] = WV'(b0); v.wt[1][1] = WV'(b1); v.wt[1][2] = WV'(b2);
      v.sg[0] = WV'(s0); v.sg[1] = WV'(s1); v.sg[2] = WV'(s2);
      v.e0 = e0;
      v.e1 = e1;
      return v;
   endfunction

   task automatic load(input vec_t v);
      for (int c = 0; c < NC; c++) begin
         s_dat[c*WV +: WV] = v.sg[c];
         for (int n = 0; n < NN; n++) w_dat[(c*NN + n)*WV +: WV] = v.wt[n][c];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a job, take it, and check latency (edges counted from the accepting edge) and sums.
   task automatic run_job(input vec_t v, input string nm);
      int cnt;
      load(v);
      w_vld = 1'b1;
      s_vld = 1'b1;
      o_rdy = 1'b0;
      #1;
      cnt = 0;
      while (!(w_rdy && s_rdy) && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({nm, " handshake"}, int'(w_rdy && s_rdy), 1);
      tick();
      w_vld = 1'b0;
      s_vld = 1'b0;
      cnt = 1;
      while (!o_vld && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({nm, " latency"}, cnt, NC + 1);
      chk({nm, " lane0"}, lane(o_dat, 0), v.e0);
      chk({nm, " lane1"}, lane(o_dat, 1), v.e1);
      o_rdy = 1'b1;
      tick();
      o_rdy = 1'b0;
      chk({nm, " valid drops"}, int'(o_vld), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NN*WA-1:0] held;
      int cnt;
      int rb[4];
      int rn[4];
      int nb, nn_cnt;
      logic pb, pn;

      tbl[0] = mk(16, 16, 16,    16, 16, 16,       16, 32, -16, 32, 32);
      tbl[1] = mk(32, 32, 32,    -16, -16, -16,    8, 8, 8,     48, -24);
      tbl[2] = mk(127, 0, 0,     -128, 0, 0,       127, 0, 0,   OV0, OV1);
      tbl[3] = mk(1, 3, -3,      16, 16, 16,       -1, 5, 7,    -3, 11);
      tbl[4] = mk(127, 127, 127, -128, -128, -128, 16, 16, 16,  381, -384);

      w_vld = 0; s_vld = 0; o_rdy = 0;
      n_w_vld = 0; n_s_vld = 0; n_o_rdy = 0;
      w_dat = '0; s_dat = '0;

      // Reset state
      tick();
      tick();
      chk("reset valid", int'(o_vld), 0);
      chk("reset data", int'(o_dat), 0);
      chk("reset w_rdy", int'(w_rdy), 0);
      chk("reset s_rdy", int'(s_rdy), 0);
      w_vld = 1'b1;
      #1;
      chk("reset s_rdy follows w_vld", int'(s_rdy), 1);
      chk("reset w_rdy lone", int'(w_rdy), 0);
      w_vld = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("vec%0d", i));

      // Lone weight valid for five cycles
      load(tbl[1]);
      w_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("lone w_rdy", int'(w_rdy), 0);
         tick();
      end
      chk("lone no job", int'(o_vld), 0);
      s_vld = 1'b1;
      #1;
      chk("lone both ready", int'(w_rdy && s_rdy), 1);
      run_job(tbl[1], "after lone");

      // Backpressure in DONE with a new job waiting; release takes it in the same cycle
      load(tbl[0]);
      w_vld = 1'b1;
      s_vld = 1'b1;
      o_rdy = 1'b0;
      tick();
      load(tbl[4]);
      cnt = 0;
      while (!o_vld && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("bp reached done", int'(o_vld), 1);
      held = o_dat;
      chk("bp lane0", lane(o_dat, 0), 32);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp data stable", int'(o_dat == held), 1);
         chk("bp valid held", int'(o_vld), 1);
         chk("bp readies low", int'(w_rdy || s_rdy), 0);
      end
      o_rdy = 1'b1;
      #1;
      chk("bp burst accept", int'(w_rdy && s_rdy), 1);
      tick();
      o_rdy = 1'b0;
      w_vld = 1'b0;
      s_vld = 1'b0;
      chk("bp single transfer", int'(o_vld), 0);
      cnt = 1;
      while (!o_vld && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("bp next latency", cnt, NC + 1);
      chk("bp next lane0", lane(o_dat, 0), 381);
      chk("bp next lane1", lane(o_dat, 1), -384);
      o_rdy = 1'b1;
      tick();
      o_rdy = 1'b0;

      // Reset at col=1
      load(tbl[3]);
      w_vld = 1'b1;
      s_vld = 1'b1;
      #1;
      chk("rst job ready", int'(w_rdy && s_rdy), 1);
      tick();
      w_vld = 1'b0;
      s_vld = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst mid-accum valid", int'(o_vld), 0);
      tick();
      rst_n = 1'b1;
      run_job(tbl[1], "post rst accum");

      // Reset while holding a result in DONE
      load(tbl[4]);
      w_vld = 1'b1;
      s_vld = 1'b1;
      tick();
      w_vld = 1'b0;
      s_vld = 1'b0;
      cnt = 0;
      while (!o_vld && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("rst done reached", int'(o_vld), 1);
      rst_n = 1'b0;
      #1;
      chk("rst mid-done valid", int'(o_vld), 0);
      chk("rst mid-done data", int'(o_dat), 0);
      tick();
      rst_n = 1'b1;
      run_job(tbl[3], "post rst done");

      // Throughput, both valids held and downstream always ready
      load(tbl[0]);
      w_vld = 1'b1; s_vld = 1'b1; o_rdy = 1'b1;
      n_w_vld = 1'b1; n_s_vld = 1'b1; n_o_rdy = 1'b1;
      nb = 0; nn_cnt = 0; pb = 1'b0; pn = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         tick();
         if (o_vld && !pb && nb < 4) begin
            rb[nb] = cyc;
            nb++;
         end
         if (n_o_vld && !pn && nn_cnt < 4) begin
            rn[nn_cnt] = cyc;
            nn_cnt++;
            chk("nburst lane0", lane(n_o_dat, 0), 32);
         end
         pb = o_vld;
         pn = n_o_vld;
      end
      chk("burst rises", int'(nb >= 3), 1);
      chk("nburst rises", int'(nn_cnt >= 3), 1);
      for (int i = 1; i < nb; i++) chk("burst period", rb[i] - rb[i-1], NC + 1);
      for (int i = 1; i < nn_cnt; i++) chk("nburst period", rn[i] - rn[i-1], NC + 2);
      w_vld = 1'b0; s_vld = 1'b0;
      n_w_vld = 1'b0; n_s_vld = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
